// File: rtl/load_cell_cond.sv
// load_cell_cond: per-side 4-sample moving average of the left/right load
// cells, registered weight/imbalance flags derived from the filtered values,
// and the saturating rider-settle timer.
module load_cell_cond #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040,
  parameter int          FAST_SIM         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        clr_tmr,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        tmr_full
);

  localparam int TW = (FAST_SIM != 0) ? 15 : 26;

  // Weight thresholds widened to the 13-bit sum domain.
  localparam logic [12:0] HI_THR = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] LO_THR = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  // Window sum divided by 4, truncated.
  function automatic logic [11:0] avg_of(input logic [13:0] acc);
    return 12'(acc >> 2);
  endfunction

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] c);
    return (&c) ? c : (c + TW'(1));
  endfunction

  logic [11:0] r_lwin_p0 [4];
  logic [11:0] r_rwin_p0 [4];
  logic [13:0] r_lacc_p0;
  logic [13:0] r_racc_p0;
  logic [2:0]  r_fill_p0;

  logic        r_gt_p1;
  logic        r_lt_p1;
  logic        r_d14_p1;
  logic        r_d1516_p1;

  logic [TW-1:0] r_tmr;

  logic [11:0] w_lavg;
  logic [11:0] w_ravg;
  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [12:0] w_sum_q4;
  logic [12:0] w_sum_15_16;

  // ---- stage p0: sliding windows and running sums, advanced on each strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_lwin_p0[i] <= '0;
        r_rwin_p0[i] <= '0;
      end
      r_lacc_p0 <= '0;
      r_racc_p0 <= '0;
      r_fill_p0 <= '0;
    end else if (ld_vld) begin
      r_lacc_p0    <= r_lacc_p0 + {2'b00, lft_ld}  - {2'b00, r_lwin_p0[3]};
      r_racc_p0    <= r_racc_p0 + {2'b00, rght_ld} - {2'b00, r_rwin_p0[3]};
      r_lwin_p0[0] <= lft_ld;
      r_rwin_p0[0] <= rght_ld;
      for (int i = 1; i < 4; i++) begin
        r_lwin_p0[i] <= r_lwin_p0[i-1];
        r_rwin_p0[i] <= r_rwin_p0[i-1];
      end
      if (r_fill_p0 < 3'd4) r_fill_p0 <= r_fill_p0 + 3'd1;
    end
  end

  // Sum, imbalance and threshold arithmetic on the filtered values.
  always_comb begin
    w_lavg      = avg_of(r_lacc_p0);
    w_ravg      = avg_of(r_racc_p0);
    w_sum       = {1'b0, w_lavg} + {1'b0, w_ravg};
    w_diff      = abs_diff(w_lavg, w_ravg);
    w_sum_q4    = w_sum >> 2;
    w_sum_15_16 = w_sum - (w_sum >> 4);
  end

  // ---- stage p1: registered flags, held at "no rider, balanced" until the window is full
  always_ff @(posedge clk) begin
    if (!rst_n || (r_fill_p0 < 3'd4)) begin
      r_gt_p1    <= 1'b0;
      r_lt_p1    <= 1'b1;
      r_d14_p1   <= 1'b0;
      r_d1516_p1 <= 1'b0;
    end else begin
      r_gt_p1    <= w_sum > HI_THR;
      r_lt_p1    <= w_sum < LO_THR;
      r_d14_p1   <= {1'b0, w_diff} > w_sum_q4;
      r_d1516_p1 <= {1'b0, w_diff} > w_sum_15_16;
    end
  end

  // Settle timer: clear wins, otherwise count up and stick at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_tmr) r_tmr <= '0;
    else                   r_tmr <= sat_inc(r_tmr);
  end

  assign sum_gt_min    = r_gt_p1;
  assign sum_lt_min    = r_lt_p1;
  assign diff_gt_1_4   = r_d14_p1;
  assign diff_gt_15_16 = r_d1516_p1;
  assign tmr_full      = &r_tmr;

endmodule

// File: tb/tb_load_cell_cond.sv
// Directed bench for load_cell_cond (FAST_SIM timer, default thresholds:
// upper 0x240, lower 0x1C0).
module tb_load_cell_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        clr_tmr;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_cell_cond #(
    .MIN_RIDER_WEIGHT(12'h200),
    .HYSTERESIS      (12'h040),
    .FAST_SIM        (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_vld       (ld_vld),
    .lft_ld       (lft_ld),
    .rght_ld      (rght_ld),
    .clr_tmr      (clr_tmr),
    .sum_gt_min   (sum_gt_min),
    .sum_lt_min   (sum_lt_min),
    .diff_gt_1_4  (diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16),
    .tmr_full     (tmr_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_flags(input string tag, input logic gt, input logic lt,
                           input logic d14, input logic d1516);
    chk({tag, ".sum_gt_min"},    sum_gt_min,    gt);
    chk({tag, ".sum_lt_min"},    sum_lt_min,    lt);
    chk({tag, ".diff_gt_1_4"},   diff_gt_1_4,   d14);
    chk({tag, ".diff_gt_15_16"}, diff_gt_15_16, d1516);
  endtask

  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    ld_vld  = 1'b1;
    lft_ld  = l;
    rght_ld = r;
    tick();
    ld_vld  = 1'b0;
  endtask

  // Four back-to-back strobes, then one more edge so the flags show them.
  task automatic fill4(input logic [11:0] l, input logic [11:0] r);
    repeat (4) strobe(l, r);
    tick();
  endtask

  initial begin
    logic held;
    rst_n   = 1'b0;
    ld_vld  = 1'b0;
    clr_tmr = 1'b0;
    lft_ld  = '0;
    rght_ld = '0;

    // Reset and fill
    tick();
    tick();
    chk_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset.tmr_full", tmr_full, 1'b0);
    rst_n = 1'b1;
    repeat (3) strobe(12'h300, 12'h300);
    tick();
    tick();
    chk_flags("fill3", 1'b0, 1'b1, 1'b0, 1'b0);
    strobe(12'h300, 12'h300);
    chk_flags("fill4_edgeN", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("fill4_edgeN1", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk_flags("stable", 1'b1, 1'b0, 1'b0, 1'b0);

    // Hysteresis band and its exact edges (sum 0x200, 0x1C0, 0x1BE, 0x240, 0x241)
    fill4(12'h100, 12'h100);
    chk_flags("band_200", 1'b0, 1'b0, 1'b0, 1'b0);
    fill4(12'h0E0, 12'h0E0);
    chk_flags("lo_edge_1C0", 1'b0, 1'b0, 1'b0, 1'b0);
    fill4(12'h0DF, 12'h0DF);
    chk_flags("below_1BE", 1'b0, 1'b1, 1'b0, 1'b0);
    fill4(12'h120, 12'h120);
    chk_flags("hi_edge_240", 1'b0, 1'b0, 1'b0, 1'b0);
    fill4(12'h121, 12'h120);
    chk_flags("above_241", 1'b1, 1'b0, 1'b0, 1'b0);

    // Imbalance: diff 0x400 vs sum/4 0x180 and 15/16 sum 0x5A0
    fill4(12'h500, 12'h100);
    chk_flags("imb_l500_r100", 1'b1, 1'b0, 1'b1, 1'b0);
    fill4(12'h100, 12'h500);
    chk_flags("imb_l100_r500", 1'b1, 1'b0, 1'b1, 1'b0);
    fill4(12'h600, 12'h000);
    chk_flags("imb_l600_r000", 1'b1, 1'b0, 1'b1, 1'b1);

    // Filtering: 0x400 window drained by zero samples (sums 0x600,0x400,0x200,0)
    fill4(12'h400, 12'h400);
    chk_flags("filt_full400", 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(12'h000, 12'h000);
    tick();
    chk_flags("filt_step1", 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(12'h000, 12'h000);
    tick();
    chk_flags("filt_step2", 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(12'h000, 12'h000);
    tick();
    chk_flags("filt_step3", 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(12'h000, 12'h000);
    tick();
    chk_flags("filt_step4", 1'b0, 1'b1, 1'b0, 1'b0);

    // Timer: clear, rise after 32767 edges, then saturate
    fill4(12'h300, 12'h300);
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    chk("tmr_after_clr", tmr_full, 1'b0);
    repeat (32766) tick();
    chk("tmr_at_32766", tmr_full, 1'b0);
    tick();
    chk("tmr_at_32767", tmr_full, 1'b1);
    held = 1'b1;
    repeat (1000) begin
      tick();
      held &= tmr_full;
    end
    chk("tmr_hold_1000", held, 1'b1);

    // Reset with timer full and window full: everything restarts
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid.tmr_full", tmr_full, 1'b0);
    chk_flags("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) strobe(12'h300, 12'h300);
    tick();
    tick();
    chk_flags("refill3", 1'b0, 1'b1, 1'b0, 1'b0);
    strobe(12'h300, 12'h300);
    tick();
    chk_flags("refill4", 1'b1, 1'b0, 1'b0, 1'b0);
    // 7 edges have passed since the reset edge
    repeat (32766 - 7) tick();
    chk("tmr_rst_32766", tmr_full, 1'b0);
    tick();
    chk("tmr_rst_32767", tmr_full, 1'b1);

    // Clear while full
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    chk("clr_while_full", tmr_full, 1'b0);
    tick();
    chk("clr_then_count", tmr_full, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
